instr_sequencer: RTL and testbench

Top-level instruction sequencer for the microcontroller. It fetches 16-bit instructions from program memory and latches them into the instruction register. It decodes the opcode class and starts the matching execution FSM: the ALU FSM for opcodes 0x8–0xE, or the load/store/move FSM for opcodes 0x0–0x7. It then waits for that FSM's done, with a watchdog, and retires the instruction.

---
 rtl/instr_sequencer.sv | 154 +++++++++++++++
 tb/tb_instr_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Top-level instruction sequencer. Fetches a 16-bit instruction from program
// memory, latches it into the instruction register, decodes the opcode class
// and kicks off either the ALU FSM (opcodes 0x8-0xE) or the load/store/move
// FSM (opcodes 0x0-0x7). It waits for the matching done under a watchdog,
// then retires the instruction. Opcode 0xF halts the sequencer. A watchdog
// expiry faults it. Both of these conditions stick until reset.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   run          enables instruction issue (sampled in IDLE and RETIRE)
//   mem_data     instruction word from program memory
//   mem_valid    mem_data valid (meaningful while fetch_req=1)
//   fetch_req    fetch request at current PC
//   ir           latched instruction word
//   alu_start    one-cycle start pulse to the ALU FSM
//   alu_done     ALU FSM completion pulse
//   ls_start     one-cycle start pulse to the load/store FSM
//   ls_done      load/store FSM completion pulse
//   busy         high except in IDLE, HALT and FAULT
//   halted       sticky, HALT opcode executed
//   fault        sticky, watchdog expired
//   instr_count  retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module instr_sequencer #(
   parameter int TIMEOUT = 32,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [15:0]        mem_data,
   input  logic               mem_valid,
   output logic               fetch_req,
   output logic [15:0]        ir,
   output logic               alu_start,
   input  logic               alu_done,
   output logic               ls_start,
   input  logic               ls_done,
   output logic               busy,
   output logic               halted,
   output logic               fault,
   output logic [COUNT_W-1:0] instr_count
);

   localparam int WD_W = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC_ALU,
      EXEC_LS,
      RETIRE,
      HALT,
      FAULT
   } state_t;

   state_t              state_reg, state_next;
   logic [WD_W-1:0]     wd_reg;
   logic [15:0]         ir_reg;
   logic [COUNT_W-1:0]  count_reg;
   logic                fetch_req_reg, alu_start_reg, ls_start_reg;
   logic                busy_reg, halted_reg, fault_reg;

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:     if (run) state_next = FETCH;
         FETCH:    if (mem_valid) state_next = DECODE;
         DECODE: begin
            if (ir_reg[15:12] == 4'hF)
               state_next = HALT;
            else if (ir_reg[15])
               state_next = EXEC_ALU;
            else
               state_next = EXEC_LS;
         end
         // done takes priority over watchdog expiry in the same cycle
         EXEC_ALU: begin
            if (alu_done)
               state_next = RETIRE;
            else if (wd_reg == WD_LAST)
               state_next = FAULT;
         end
         EXEC_LS: begin
            if (ls_done)
               state_next = RETIRE;
            else if (wd_reg == WD_LAST)
               state_next = FAULT;
         end
         RETIRE:   state_next = run ? FETCH : IDLE;
         HALT:     state_next = HALT;
         FAULT:    state_next = FAULT;
         default:  state_next = IDLE;
      endcase
   end

   // State, datapath and registered outputs. The outputs are computed from
   // state_next so that they line up with the state they describe while still
   // coming straight out of flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         wd_reg        <= '0;
         ir_reg        <= '0;
         count_reg     <= '0;
         fetch_req_reg <= 1'b0;
         alu_start_reg <= 1'b0;
         ls_start_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         halted_reg    <= 1'b0;
         fault_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;

         if (state_reg == FETCH && mem_valid)
            ir_reg <= mem_data;

         // Watchdog is cleared on the way into EXEC and counts EXEC cycles
         if (state_reg == DECODE)
            wd_reg <= '0;
         else if (state_reg == EXEC_ALU || state_reg == EXEC_LS)
            wd_reg <= wd_reg + 1'b1;

         if (state_reg == RETIRE)
            count_reg <= count_reg + 1'b1;

         fetch_req_reg <= (state_next == FETCH);
         // Start pulses only on entry into EXEC (from DECODE)
         alu_start_reg <= (state_next == EXEC_ALU) && (state_reg == DECODE);
         ls_start_reg  <= (state_next == EXEC_LS)  && (state_reg == DECODE);
         busy_reg      <= !(state_next == IDLE || state_next == HALT ||
                            state_next == FAULT);
         halted_reg    <= (state_next == HALT);
         fault_reg     <= (state_next == FAULT);
      end
   end

   assign fetch_req   = fetch_req_reg;
   assign ir          = ir_reg;
   assign alu_start   = alu_start_reg;
   assign ls_start    = ls_start_reg;
   assign busy        = busy_reg;
   assign halted      = halted_reg;
   assign fault       = fault_reg;
   assign instr_count = count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. Instance u_a uses default parameters,
// instance u_b uses TIMEOUT=8, COUNT_W=4 for watchdog and wrap scenarios.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   logic clk;
   logic rst;

   logic        a_run, a_mem_valid, a_alu_done, a_ls_done;
   logic [15:0] a_mem_data;
   logic        a_fetch_req, a_alu_start, a_ls_start, a_busy, a_halted, a_fault;
   logic [15:0] a_ir;
   logic [15:0] a_count;

   logic        b_run, b_mem_valid, b_alu_done, b_ls_done;
   logic [15:0] b_mem_data;
   logic        b_fetch_req, b_alu_start, b_ls_start, b_busy, b_halted, b_fault;
   logic [15:0] b_ir;
   logic [3:0]  b_count;

   int errors = 0;
   int checks = 0;

   instr_sequencer u_a (
      .clk(clk), .rst(rst), .run(a_run), .mem_data(a_mem_data),
      .mem_valid(a_mem_valid), .fetch_req(a_fetch_req), .ir(a_ir),
      .alu_start(a_alu_start), .alu_done(a_alu_done), .ls_start(a_ls_start),
      .ls_done(a_ls_done), .busy(a_busy), .halted(a_halted), .fault(a_fault),
      .instr_count(a_count)
   );

   instr_sequencer #(.TIMEOUT(8), .COUNT_W(4)) u_b (
      .clk(clk), .rst(rst), .run(b_run), .mem_data(b_mem_data),
      .mem_valid(b_mem_valid), .fetch_req(b_fetch_req), .ir(b_ir),
      .alu_start(b_alu_start), .alu_done(b_alu_done), .ls_start(b_ls_start),
      .ls_done(b_ls_done), .busy(b_busy), .halted(b_halted), .fault(b_fault),
      .instr_count(b_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b0;
      a_run = 0; a_mem_valid = 0; a_alu_done = 0; a_ls_done = 0; a_mem_data = '0;
      b_run = 0; b_mem_valid = 0; b_alu_done = 0; b_ls_done = 0; b_mem_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      checks++;
      if ({a_fetch_req, a_alu_start, a_ls_start, a_busy, a_halted, a_fault} !== 6'b0) begin
         errors++;
         $display("FAIL reset_a_flags: got %b want 000000",
                  {a_fetch_req, a_alu_start, a_ls_start, a_busy, a_halted, a_fault});
      end
      checks++;
      if (a_ir !== 16'h0000 || a_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_a_regs: got ir=%h cnt=%0d want ir=0000 cnt=0", a_ir, a_count);
      end
      checks++;
      if ({b_fetch_req, b_busy, b_halted, b_fault} !== 4'b0 || b_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_b: got flags=%b cnt=%0d want 0000 cnt=0",
                  {b_fetch_req, b_busy, b_halted, b_fault}, b_count);
      end
      $display("tx reset: outputs checked");
   endtask

   // ALU instruction 0x8042, alu_done in 10th EXEC cycle
   task automatic test_alu();
      int n_alu, n_ls;
      n_alu = 0; n_ls = 0;
      do_reset();
      a_run = 1;
      @(negedge clk);                               // FETCH
      checks++;
      if (a_fetch_req !== 1'b1 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL alu_fetch: got req=%b busy=%b want 1 1", a_fetch_req, a_busy);
      end
      a_mem_valid = 1; a_mem_data = 16'h8042;
      @(negedge clk);                               // DECODE
      a_mem_valid = 0; a_mem_data = 16'h1234;
      checks++;
      if (a_fetch_req !== 1'b0 || a_ir !== 16'h8042) begin
         errors++;
         $display("FAIL alu_decode: got req=%b ir=%h want 0 8042", a_fetch_req, a_ir);
      end
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);                            // EXEC cycle i
         if (a_alu_start) n_alu++;
         if (a_ls_start) n_ls++;
         if (i == 10) a_alu_done = 1;
      end
      @(negedge clk);                               // RETIRE
      a_alu_done = 0;
      if (a_alu_start) n_alu++;
      if (a_ls_start) n_ls++;
      checks++;
      if (n_alu !== 1 || n_ls !== 0) begin
         errors++;
         $display("FAIL alu_starts: got alu=%0d ls=%0d want 1 0", n_alu, n_ls);
      end
      checks++;
      if (a_fetch_req !== 1'b0 || a_ir !== 16'h8042 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL alu_retire: got req=%b ir=%h busy=%b want 0 8042 1",
                  a_fetch_req, a_ir, a_busy);
      end
      @(negedge clk);                               // next FETCH
      checks++;
      if (a_fetch_req !== 1'b1 || a_count !== 16'd1) begin
         errors++;
         $display("FAIL alu_next: got req=%b cnt=%0d want 1 1", a_fetch_req, a_count);
      end
      $display("tx alu: ir=%h count=%0d", a_ir, a_count);
   endtask

   // Load/store 0x3001: alu_done in EXEC 2 ignored, ls_done in EXEC 3
   task automatic test_ls();
      int n_alu, n_ls;
      n_alu = 0; n_ls = 0;
      do_reset();
      a_run = 1;
      @(negedge clk);                               // FETCH
      a_mem_valid = 1; a_mem_data = 16'h3001;
      @(negedge clk);                               // DECODE
      a_mem_valid = 0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         if (a_alu_start) n_alu++;
         if (a_ls_start) n_ls++;
         a_alu_done = (i == 2);
         a_ls_done  = (i == 3);
         if (i == 3) begin
            checks++;
            if (a_fetch_req !== 1'b0 || a_busy !== 1'b1) begin
               errors++;
               $display("FAIL ls_exec3: got req=%b busy=%b want 0 1", a_fetch_req, a_busy);
            end
         end
      end
      @(negedge clk);                               // RETIRE
      a_ls_done = 0;
      checks++;
      if (n_ls !== 1 || n_alu !== 0) begin
         errors++;
         $display("FAIL ls_starts: got ls=%0d alu=%0d want 1 0", n_ls, n_alu);
      end
      checks++;
      if (a_fetch_req !== 1'b0 || a_ir !== 16'h3001) begin
         errors++;
         $display("FAIL ls_retire: got req=%b ir=%h want 0 3001", a_fetch_req, a_ir);
      end
      @(negedge clk);                               // FETCH
      checks++;
      if (a_fetch_req !== 1'b1 || a_count !== 16'd1) begin
         errors++;
         $display("FAIL ls_next: got req=%b cnt=%0d want 1 1", a_fetch_req, a_count);
      end
      $display("tx ls: ir=%h count=%0d", a_ir, a_count);
   endtask

   // Continues from test_ls (u_a in FETCH with count=1); reset in EXEC 3
   task automatic test_reset_mid_exec();
      a_mem_valid = 1; a_mem_data = 16'h8042;
      @(negedge clk);                               // DECODE
      a_mem_valid = 0;
      repeat (3) @(negedge clk);                    // EXEC 3
      rst = 1'b0;
      #1;
      checks++;
      if ({a_fetch_req, a_alu_start, a_ls_start, a_busy, a_halted, a_fault} !== 6'b0 ||
          a_ir !== 16'h0 || a_count !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset: got flags=%b ir=%h cnt=%0d want 000000 0000 0",
                  {a_fetch_req, a_alu_start, a_ls_start, a_busy, a_halted, a_fault},
                  a_ir, a_count);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (a_fetch_req !== 1'b1 || a_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_resume: got req=%b busy=%b want 1 1", a_fetch_req, a_busy);
      end
      $display("tx reset_mid_exec: resumed req=%b", a_fetch_req);
   endtask

   task automatic test_watchdog();
      int bad;
      do_reset();
      b_run = 1;
      @(negedge clk);                               // FETCH
      b_mem_valid = 1; b_mem_data = 16'hA000;
      @(negedge clk);                               // DECODE
      b_mem_valid = 0;
      bad = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (b_fault !== 1'b0 || b_busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wd_early: got %0d bad EXEC cycles want 0", bad);
      end
      @(negedge clk);
      checks++;
      if (b_fault !== 1'b1 || b_busy !== 1'b0 || b_fetch_req !== 1'b0) begin
         errors++;
         $display("FAIL wd_fault: got fault=%b busy=%b req=%b want 1 0 0",
                  b_fault, b_busy, b_fetch_req);
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         b_alu_done = i[0]; b_ls_done = ~i[0]; b_run = i[1]; b_mem_valid = 1;
         @(negedge clk);
         if (b_fault !== 1'b1 || b_fetch_req !== 1'b0 || b_alu_start !== 1'b0 ||
             b_ls_start !== 1'b0 || b_busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wd_sticky: got %0d bad cycles want 0", bad);
      end
      $display("tx watchdog: fault=%b", b_fault);

      // Rerun: done in 8th EXEC cycle wins over expiry
      do_reset();
      b_run = 1;
      @(negedge clk);
      b_mem_valid = 1; b_mem_data = 16'hA000;
      @(negedge clk);
      b_mem_valid = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (i == 8) b_alu_done = 1;
      end
      @(negedge clk);                               // RETIRE
      b_alu_done = 0;
      checks++;
      if (b_fault !== 1'b0 || b_busy !== 1'b1) begin
         errors++;
         $display("FAIL wd_edge_retire: got fault=%b busy=%b want 0 1", b_fault, b_busy);
      end
      @(negedge clk);
      checks++;
      if (b_count !== 4'd1 || b_fetch_req !== 1'b1) begin
         errors++;
         $display("FAIL wd_edge_count: got cnt=%0d req=%b want 1 1", b_count, b_fetch_req);
      end
      $display("tx watchdog_edge: count=%0d", b_count);
   endtask

   task automatic test_halt();
      int bad;
      do_reset();
      a_run = 1;
      @(negedge clk);
      a_mem_valid = 1; a_mem_data = 16'hF000;
      @(negedge clk);                               // DECODE
      @(negedge clk);                               // HALT
      checks++;
      if (a_halted !== 1'b1 || a_busy !== 1'b0 || a_count !== 16'd0) begin
         errors++;
         $display("FAIL halt_enter: got halted=%b busy=%b cnt=%0d want 1 0 0",
                  a_halted, a_busy, a_count);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_fetch_req !== 1'b0 || a_halted !== 1'b1 || a_count !== 16'd0) bad++;
      end
      a_mem_valid = 0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL halt_hold: got %0d bad cycles want 0", bad);
      end
      $display("tx halt: halted=%b count=%0d", a_halted, a_count);
   endtask

   // Back-to-back one-cycle ALU instructions: 4 cycles each, count wraps
   task automatic test_back_to_back();
      do_reset();
      b_run = 1; b_mem_valid = 1; b_mem_data = 16'h8000; b_alu_done = 1;
      @(negedge clk);                               // FETCH, count 0
      repeat (15 * 4) @(negedge clk);
      checks++;
      if (b_count !== 4'd15 || b_fetch_req !== 1'b1) begin
         errors++;
         $display("FAIL b2b_15: got cnt=%0d req=%b want 15 1", b_count, b_fetch_req);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (b_count !== 4'd0 || b_fetch_req !== 1'b1) begin
         errors++;
         $display("FAIL b2b_wrap: got cnt=%0d req=%b want 0 1", b_count, b_fetch_req);
      end
      $display("tx back_to_back: count=%0d", b_count);

      // run dropped during EXEC still retires, then IDLE
      b_alu_done = 0;
      @(negedge clk);                               // DECODE
      b_mem_valid = 0;
      @(negedge clk);                               // EXEC 1
      b_run = 0;
      @(negedge clk);                               // EXEC 2
      b_alu_done = 1;
      @(negedge clk);                               // RETIRE
      b_alu_done = 0;
      checks++;
      if (b_busy !== 1'b1) begin
         errors++;
         $display("FAIL run_drop_retire: got busy=%b want 1", b_busy);
      end
      @(negedge clk);                               // IDLE
      checks++;
      if (b_busy !== 1'b0 || b_fetch_req !== 1'b0 || b_count !== 4'd1) begin
         errors++;
         $display("FAIL run_drop_idle: got busy=%b req=%b cnt=%0d want 0 0 1",
                  b_busy, b_fetch_req, b_count);
      end
      $display("tx run_drop: count=%0d", b_count);
   endtask

   initial begin
      do_reset();
      test_reset();
      test_alu();
      test_ls();
      test_reset_mid_exec();
      test_watchdog();
      test_halt();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
